// File: rtl/issue_queue.sv
// Issue queue: FIFO between the schedule stage and execute/dispatch.
// Ops leave in push order, first-word-fall-through, with back-pressure to the scheduler.
package issue_queue_pkg;

   typedef struct packed {
      logic [3:0]  rob_tag;
      logic [5:0]  opcode;
      logic [4:0]  dst;
      logic [15:0] imm;
   } res_st_cell_t;

endpackage

module issue_queue
   import issue_queue_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               wr_en,
   input  res_st_cell_t       op_in,
   output logic               sched_en,
   output logic               op_valid,
   input  logic               op_ready,
   output res_st_cell_t       op_out,
   output logic [CNT_W-1:0]   count,
   output logic               overflow
);

   res_st_cell_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             push;
   logic             pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign sched_en = !full;
   assign op_valid = (count != '0);
   assign op_out   = op_valid ? mem[rd_ptr] : '0;

   assign push = wr_en && !full;
   assign pop  = op_valid && op_ready;

   // Storage is never reset; only pointers and occupancy decide what is visible.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push) begin
         mem[wr_ptr] <= op_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         // A full queue drops the op even if the head leaves this same cycle.
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus a random run,
// all compared against a queue-based reference model.
module tb_issue_queue;
   import issue_queue_pkg::*;

   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         wr_en;
   logic         op_ready;
   res_st_cell_t op_in;
   res_st_cell_t op_out;
   logic         sched_en;
   logic         op_valid;
   logic         overflow;
   logic [3:0]   count;

   res_st_cell_t q[$];
   bit           m_ovf;
   int           checks = 0;
   int           errors = 0;

   issue_queue #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .wr_en    (wr_en),
      .op_in    (op_in),
      .sched_en (sched_en),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_out   (op_out),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   function automatic res_st_cell_t rand_op();
      logic [31:0] r;
      r = $urandom;
      return res_st_cell_t'(r[30:0]);
   endfunction

   function automatic res_st_cell_t exp_head();
      res_st_cell_t h;
      h = '0;
      if (q.size() != 0) h = q[0];
      return h;
   endfunction

   // Reference behaviour: a plain queue of ops plus a sticky overflow bit.
   function automatic void model_step();
      bit was_full;
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
      end else if (flush) begin
         q.delete();
      end else begin
         was_full = (q.size() == DEPTH);
         if (wr_en && was_full) m_ovf = 1'b1;
         if (op_ready && q.size() != 0) void'(q.pop_front());
         if (wr_en && !was_full) q.push_back(op_in);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b1; op_in = rand_op();
      tick();
      op_in = rand_op();
      tick();
      rst = 1'b0; wr_en = 1'b0;
      checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", count); end
      checks++; if (op_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", op_valid); end
      checks++; if (op_out !== '0) begin errors++; $display("[TB] FAIL reset_out got %h exp 0", op_out); end
      checks++; if (sched_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_sched_en got %b exp 1", sched_en); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b exp 0", overflow); end
   endtask

   task automatic test_latency_order();
      res_st_cell_t ops[3];
      foreach (ops[i]) ops[i] = rand_op();
      op_ready = 1'b0; wr_en = 1'b1; op_in = ops[0];
      #1;
      checks++; if (op_valid !== 1'b0) begin errors++; $display("[TB] FAIL no_bypass got %b exp 0", op_valid); end
      tick();
      checks++; if (op_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid got %b exp 1", op_valid); end
      checks++; if (op_out !== ops[0]) begin errors++; $display("[TB] FAIL first_head got %h exp %h", op_out, ops[0]); end
      op_in = ops[1]; tick();
      op_in = ops[2]; tick();
      wr_en = 1'b0;
      checks++; if (count !== 4'd3) begin errors++; $display("[TB] FAIL lat_count got %0d exp 3", count); end
      op_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (op_out !== ops[i]) begin errors++; $display("[TB] FAIL order_%0d got %h exp %h", i, op_out, ops[i]); end
         tick();
      end
      op_ready = 1'b0;
      checks++; if (op_valid !== 1'b0) begin errors++; $display("[TB] FAIL drained_valid got %b exp 0", op_valid); end
   endtask

   task automatic test_full();
      res_st_cell_t ops[8];
      op_ready = 1'b0; wr_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ops[i] = rand_op(); op_in = ops[i];
         tick();
      end
      wr_en = 1'b0;
      checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL full_count got %0d exp 8", count); end
      checks++; if (sched_en !== 1'b0) begin errors++; $display("[TB] FAIL full_sched_en got %b exp 0", sched_en); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pre_overflow got %b exp 0", overflow); end
      wr_en = 1'b1; op_in = rand_op(); op_ready = 1'b1;
      tick();
      wr_en = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set got %b exp 1", overflow); end
      checks++; if (count !== 4'd7) begin errors++; $display("[TB] FAIL full_pop_count got %0d exp 7", count); end
      for (int i = 1; i < 8; i++) begin
         checks++; if (op_out !== ops[i]) begin errors++; $display("[TB] FAIL full_order_%0d got %h exp %h", i, op_out, ops[i]); end
         tick();
      end
      op_ready = 1'b0;
      checks++; if (op_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drained got %b exp 0", op_valid); end
   endtask

   task automatic test_wrap();
      res_st_cell_t pushed[$];
      res_st_cell_t popped[$];
      int cyc = 0;
      op_ready = 1'b1;
      while (pushed.size() < 20 && cyc < 200) begin
         wr_en = ($urandom_range(0, 3) != 0);
         op_in = rand_op();
         checks++; if (op_out !== exp_head()) begin errors++; $display("[TB] FAIL wrap_head got %h exp %h", op_out, exp_head()); end
         checks++; if (count !== 4'(q.size()) || count > 4'd2) begin errors++; $display("[TB] FAIL wrap_count got %0d exp %0d", count, q.size()); end
         if (op_valid) popped.push_back(op_out);
         if (wr_en) pushed.push_back(op_in);
         tick();
         cyc++;
      end
      wr_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (op_valid) popped.push_back(op_out);
         tick();
      end
      op_ready = 1'b0;
      checks++; if (pushed.size() != 20) begin errors++; $display("[TB] FAIL wrap_timeout got %0d exp 20", pushed.size()); end
      checks++; if (popped.size() != pushed.size()) begin errors++; $display("[TB] FAIL wrap_popcount got %0d exp %0d", popped.size(), pushed.size()); end
      for (int i = 0; i < popped.size() && i < pushed.size(); i++) begin
         checks++; if (popped[i] !== pushed[i]) begin errors++; $display("[TB] FAIL wrap_order_%0d got %h exp %h", i, popped[i], pushed[i]); end
      end
   endtask

   task automatic test_simultaneous();
      op_ready = 1'b0; wr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin op_in = rand_op(); tick(); end
      op_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         op_in = rand_op();
         checks++; if (op_out !== exp_head()) begin errors++; $display("[TB] FAIL sim_head_%0d got %h exp %h", i, op_out, exp_head()); end
         tick();
         checks++; if (count !== 4'd4) begin errors++; $display("[TB] FAIL sim_count_%0d got %0d exp 4", i, count); end
      end
      wr_en = 1'b0;
      for (int i = 0; i < 6 && q.size() != 0; i++) begin
         checks++; if (op_out !== exp_head()) begin errors++; $display("[TB] FAIL sim_drain_%0d got %h exp %h", i, op_out, exp_head()); end
         tick();
      end
      op_ready = 1'b0;
      checks++; if (op_valid !== 1'b0) begin errors++; $display("[TB] FAIL sim_drained got %b exp 0", op_valid); end
   endtask

   task automatic test_flush_reset();
      res_st_cell_t lost;
      res_st_cell_t fresh;
      op_ready = 1'b0; wr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin op_in = rand_op(); tick(); end
      lost = rand_op();
      op_in = lost; op_ready = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; wr_en = 1'b0; op_ready = 1'b0;
      checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL flush_count got %0d exp 0", count); end
      checks++; if (op_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b exp 0", op_valid); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("[TB] FAIL flush_overflow got %b exp %b", overflow, m_ovf); end
      fresh = rand_op();
      wr_en = 1'b1; op_in = fresh;
      tick();
      wr_en = 1'b0;
      checks++; if (op_out !== fresh) begin errors++; $display("[TB] FAIL flush_fresh got %h exp %h", op_out, fresh); end
      op_ready = 1'b1; tick(); op_ready = 1'b0;
      wr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin op_in = rand_op(); tick(); end
      op_ready = 1'b1; rst = 1'b1; op_in = rand_op();
      tick();
      rst = 1'b0; wr_en = 1'b0; op_ready = 1'b0;
      checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL rst_count got %0d exp 0", count); end
      checks++; if (op_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b exp 0", op_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_overflow got %b exp 0", overflow); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         checks++; if (count !== 4'(q.size())) begin errors++; $display("[TB] FAIL rnd_count_%0d got %0d exp %0d", i, count, q.size()); end
         checks++; if (op_out !== exp_head()) begin errors++; $display("[TB] FAIL rnd_head_%0d got %h exp %h", i, op_out, exp_head()); end
         checks++; if (op_valid !== (q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_valid_%0d got %b exp %b", i, op_valid, q.size() != 0); end
         checks++; if (sched_en !== (q.size() < DEPTH)) begin errors++; $display("[TB] FAIL rnd_sched_en_%0d got %b exp %b", i, sched_en, q.size() < DEPTH); end
         checks++; if (overflow !== m_ovf) begin errors++; $display("[TB] FAIL rnd_overflow_%0d got %b exp %b", i, overflow, m_ovf); end
         rst      = ($urandom_range(0, 149) == 0);
         flush    = ($urandom_range(0, 39) == 0);
         wr_en    = ($urandom_range(0, 9) < 7);
         op_ready = ($urandom_range(0, 9) < 4);
         op_in    = rand_op();
         tick();
      end
      rst = 1'b0; flush = 1'b0; wr_en = 1'b0; op_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; wr_en = 1'b0; op_ready = 1'b0; op_in = '0;
      m_ovf = 1'b0;
      @(negedge clk);
      test_reset();
      test_latency_order();
      test_full();
      test_wrap();
      test_simultaneous();
      test_flush_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout exp completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
